// File: rtl/symb_clk_div.sv
// symb_clk_div: multi-channel programmable clock-enable divider.
// Each channel divides the qualified clock (clk & clk_en) by its ratio N and
// produces a one-cycle tick plus a near-50% level. While a channel is running,
// ratio changes are shadowed and applied at the next period boundary or on sync.
module symb_clk_div #(
  parameter int NCH     = 4,
  parameter int CH_W    = 2,
  parameter int DIV_W   = 16,
  parameter int DEF_DIV = 1
) (
  input  logic             clk,
  input  logic             rs,
  input  logic             clk_en,
  input  logic             sync,
  input  logic             cfg_we,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic             cfg_en,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [CH_W-1:0]  rd_ch,
  output logic [DIV_W-1:0] rd_div,
  output logic             rd_en,
  output logic             rd_pend,
  output logic [NCH-1:0]   tick_out,
  output logic [NCH-1:0]   lvl_out
);

  // Readback mux spans every encodable channel number so out-of-range
  // selections read the zero padding entries.
  localparam int NSEL = 2**CH_W;
  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
  localparam logic [DIV_W-1:0] DEF_N   = DIV_W'(DEF_DIV);

  logic [DIV_W-1:0] w_act_sel [NSEL];
  logic [NSEL-1:0]  w_en_sel;
  logic [NSEL-1:0]  w_pend_sel;

  for (genvar gi = 0; gi < NSEL; gi++) begin : g_sel
    if (gi < NCH) begin : g_ch
      logic [DIV_W-1:0] r_act;
      logic [DIV_W-1:0] r_pnd;
      logic [DIV_W-1:0] r_cnt;
      logic             r_pend;
      logic             r_en;
      logic             r_tick;
      logic             r_lvl;

      logic             w_hit;
      logic             w_load;
      logic             w_shadow;
      logic             w_bypass;
      logic             w_wrap;
      logic [DIV_W-1:0] w_newn;
      logic [DIV_W-1:0] w_cnt_inc;
      logic [DIV_W-1:0] w_last;

      assign w_hit     = cfg_we && (cfg_ch == CH_W'(gi));
      // A write to an idle channel, or one that disables it, takes effect at once.
      assign w_load    = w_hit && (!r_en || !cfg_en);
      // A write to a running channel that keeps it running is shadowed.
      assign w_shadow  = w_hit && r_en && cfg_en;
      assign w_bypass  = (r_act <= DIV_ONE);
      assign w_cnt_inc = r_cnt + DIV_ONE;
      assign w_last    = r_act - DIV_ONE;
      // In bypass every qualified cycle ends a period.
      assign w_wrap    = clk_en && (w_bypass || (r_cnt == w_last));
      // Ratio for the period that begins on a wrap or sync; a same-cycle
      // write beats the shadow register.
      assign w_newn    = w_shadow ? cfg_div : (r_pend ? r_pnd : r_act);

      // Per-channel divider state: load, sync realign, wrap, count.
      always_ff @(posedge clk) begin
        if (rs) begin
          r_act  <= DEF_N;
          r_pnd  <= '0;
          r_pend <= 1'b0;
          r_en   <= 1'b0;
          r_cnt  <= '0;
          r_tick <= 1'b0;
          r_lvl  <= 1'b0;
        end else if (w_load) begin
          r_act  <= cfg_div;
          r_en   <= cfg_en;
          r_pend <= 1'b0;
          r_cnt  <= '0;
          r_tick <= 1'b0;
          r_lvl  <= 1'b0;
        end else if (!r_en) begin
          r_cnt  <= '0;
          r_tick <= 1'b0;
          r_lvl  <= 1'b0;
        end else if (sync) begin
          r_act  <= w_newn;
          r_pend <= 1'b0;
          r_cnt  <= '0;
          r_tick <= 1'b0;
          r_lvl  <= (w_newn > DIV_ONE);
        end else if (w_wrap) begin
          r_act  <= w_newn;
          r_pend <= 1'b0;
          r_cnt  <= '0;
          r_tick <= 1'b1;
          // A counted period restarts high; bypass keeps toggling.
          r_lvl  <= (w_newn > DIV_ONE) ? 1'b1 : ~r_lvl;
        end else begin
          r_tick <= 1'b0;
          if (w_shadow) begin
            r_pnd  <= cfg_div;
            r_pend <= 1'b1;
          end
          if (clk_en) begin
            r_cnt <= w_cnt_inc;
            r_lvl <= (w_cnt_inc < (r_act >> 1));
          end
        end
      end

      assign tick_out[gi]   = r_tick;
      assign lvl_out[gi]    = r_lvl;
      assign w_act_sel[gi]  = r_act;
      assign w_en_sel[gi]   = r_en;
      assign w_pend_sel[gi] = r_pend;
    end else begin : g_pad
      assign w_act_sel[gi]  = '0;
      assign w_en_sel[gi]   = 1'b0;
      assign w_pend_sel[gi] = 1'b0;
    end
  end

  // Registered readback of the selected channel's state.
  always_ff @(posedge clk) begin
    if (rs) begin
      rd_div  <= '0;
      rd_en   <= 1'b0;
      rd_pend <= 1'b0;
    end else begin
      rd_div  <= w_act_sel[rd_ch];
      rd_en   <= w_en_sel[rd_ch];
      rd_pend <= w_pend_sel[rd_ch];
    end
  end

endmodule
